// File: rtl/trace_fifo.sv
// Trace word buffer: first-word-fall-through FIFO between the tracer strobe and a
// valid/ready export sink, with drop accounting and peak-occupancy tracking.
module trace_fifo #(
  parameter int TRACE_WIDTH = 128,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       trace_valid_i,
  input  logic [TRACE_WIDTH-1:0]     trace_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [TRACE_WIDTH-1:0]     out_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     high_water_o,
  output logic                       overflow_o,
  output logic [CNT_WIDTH-1:0]       drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TRACE_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          level;
  logic [PW-1:0]          level_nxt;
  logic [PW-1:0]          high_water;
  logic [CNT_WIDTH-1:0]   drop_count;
  logic                   overflow;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign pop  = !empty && out_ready_i;
  assign push = trace_valid_i && (!full || pop) && !flush_i;
  assign drop = trace_valid_i && full && !pop && !flush_i;

  always_comb begin
    level_nxt = level;
    if (flush_i)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = level + PW'(1);
    else if (pop && !push)
      level_nxt = level - PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      high_water <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      level <= level_nxt;
      if (level_nxt > high_water)
        high_water <= level_nxt;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; out_valid_o gates its contents.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= trace_i;
  end

  assign out_valid_o  = !empty;
  assign out_data_o   = mem[rd_ptr[AW-1:0]];
  assign level_o      = level;
  assign full_o       = full;
  assign high_water_o = high_water;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_count;

endmodule
